tpu_sequencer: RTL and testbench

TPU_SEQUENCER -- requirements
Module: tpu_sequencer

---
 rtl/tpu_pkg.sv | 19 +
 rtl/tpu_sequencer_if.sv | 43 ++++
 rtl/tpu_sequencer.sv | 134 +++++++++++++
 tb/tb_tpu_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants for the TPU command sequencer: opcodes, FSM states, operand width.
package tpu_pkg;

    localparam int NBYTES_DEF = 8;

    localparam logic [7:0] OP_LOAD_A = 8'h01;
    localparam logic [7:0] OP_LOAD_B = 8'h02;
    localparam logic [7:0] OP_MAC    = 8'h03;
    localparam logic [7:0] OP_CLEAR  = 8'h04;
    localparam logic [7:0] OP_READ   = 8'h05;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_READ
    } state_e;

endpackage

// File: rtl/tpu_sequencer_if.sv
// Sequencer bus: command byte stream in, operand write/MAC controls to the datapath,
// result byte stream out. master = sequencer, slave = host/datapath side.
interface tpu_sequencer_if;

    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;

    logic       wr_a_en;
    logic       wr_b_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_byte;

    logic       acc_en;
    logic       acc_clr;

    logic [2:0] res_sel;
    logic [7:0] res_byte;

    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;

    logic       a_loaded;
    logic       b_loaded;
    logic       busy;
    logic       err;

    modport master (
        input  in_byte, in_valid, res_byte, out_ready,
        output in_ready, wr_a_en, wr_b_en, wr_idx, wr_byte,
               acc_en, acc_clr, res_sel, out_byte, out_valid,
               a_loaded, b_loaded, busy, err
    );

    modport slave (
        output in_byte, in_valid, res_byte, out_ready,
        input  in_ready, wr_a_en, wr_b_en, wr_idx, wr_byte,
               acc_en, acc_clr, res_sel, out_byte, out_valid,
               a_loaded, b_loaded, busy, err
    );

endinterface

// File: rtl/tpu_sequencer.sv
// Byte-serial command sequencer for a 64-bit MAC datapath: loads operands A/B,
// fires MAC/clear pulses and streams the result back out one byte at a time.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input logic             clk,
    input logic             rst,
    tpu_sequencer_if.master bus
);

    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

    state_e     state_q;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       tgt_b_q;
    logic       wr_a_q;
    logic       wr_b_q;
    logic [2:0] wr_idx_q;
    logic [7:0] wr_byte_q;
    logic       acc_en_q;
    logic       acc_clr_q;
    logic       a_ld_q;
    logic       b_ld_q;
    logic       err_q;

    logic in_fire;
    logic out_fire;
    logic last_byte;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign cnt_d     = cnt_q + 3'd1;
    assign last_byte = (cnt_q == LAST_IDX);

    // Load and read share one counter; they can never be active at the same time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            tgt_b_q   <= 1'b0;
            wr_a_q    <= 1'b0;
            wr_b_q    <= 1'b0;
            wr_idx_q  <= 3'd0;
            wr_byte_q <= 8'd0;
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            a_ld_q    <= 1'b0;
            b_ld_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_a_q    <= 1'b0;
            wr_b_q    <= 1'b0;
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_fire) begin
                        case (bus.in_byte)
                            OP_LOAD_A: begin
                                state_q <= S_LOAD;
                                tgt_b_q <= 1'b0;
                                a_ld_q  <= 1'b0;
                                cnt_q   <= 3'd0;
                            end
                            OP_LOAD_B: begin
                                state_q <= S_LOAD;
                                tgt_b_q <= 1'b1;
                                b_ld_q  <= 1'b0;
                                cnt_q   <= 3'd0;
                            end
                            OP_MAC: begin
                                if (a_ld_q && b_ld_q) begin
                                    state_q  <= S_EXEC;
                                    acc_en_q <= 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OP_CLEAR: acc_clr_q <= 1'b1;
                            OP_READ: begin
                                state_q <= S_READ;
                                cnt_q   <= 3'd0;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        wr_a_q    <= !tgt_b_q;
                        wr_b_q    <= tgt_b_q;
                        wr_idx_q  <= cnt_q;
                        wr_byte_q <= bus.in_byte;
                        cnt_q     <= cnt_d;
                        if (last_byte) begin
                            state_q <= S_IDLE;
                            if (tgt_b_q) b_ld_q <= 1'b1;
                            else         a_ld_q <= 1'b1;
                        end
                    end
                end
                S_EXEC: state_q <= S_IDLE;
                S_READ: begin
                    if (out_fire) begin
                        cnt_q <= cnt_d;
                        if (last_byte) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // in_ready is forced low while reset is held so nothing is taken during reset.
    assign bus.in_ready  = rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign bus.out_valid = (state_q == S_READ);
    assign bus.res_sel   = cnt_q;
    assign bus.out_byte  = bus.res_byte;
    assign bus.busy      = (state_q != S_IDLE);

    assign bus.wr_a_en   = wr_a_q;
    assign bus.wr_b_en   = wr_b_q;
    assign bus.wr_idx    = wr_idx_q;
    assign bus.wr_byte   = wr_byte_q;
    assign bus.acc_en    = acc_en_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.a_loaded  = a_ld_q;
    assign bus.b_loaded  = b_ld_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed then randomized command stream against a flag/event-count model of the sequencer.
module tb_tpu_sequencer;
    import tpu_pkg::*;

    localparam int NB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] res_base = 8'hA0;

    always #5 clk = ~clk;

    tpu_sequencer_if bus();
    assign bus.res_byte = res_base + {5'd0, bus.res_sel};

    tpu_sequencer #(.NBYTES(NB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // observed event counts and captured operand bytes
    int n_wa = 0, n_wb = 0, n_acc = 0, n_clr = 0, n_excl = 0;
    logic [7:0] mem_a [NB];
    logic [7:0] mem_b [NB];

    // reference model state
    logic m_a = 1'b0, m_b = 1'b0, m_err = 1'b0;
    int   e_wa = 0, e_wb = 0, e_acc = 0, e_clr = 0;

    always @(negedge clk) begin
        if (bus.wr_a_en) begin
            n_wa <= n_wa + 1;
            mem_a[bus.wr_idx] <= bus.wr_byte;
        end
        if (bus.wr_b_en) begin
            n_wb <= n_wb + 1;
            mem_b[bus.wr_idx] <= bus.wr_byte;
        end
        if (bus.acc_en)  n_acc <= n_acc + 1;
        if (bus.acc_clr) n_clr <= n_clr + 1;
        if ((32'(bus.wr_a_en) + 32'(bus.wr_b_en) + 32'(bus.acc_en) + 32'(bus.acc_clr)) > 1)
            n_excl <= n_excl + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte; returns 1ns after the accepting edge.
    task automatic push(input logic [7:0] b);
        int g = 0;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 50) begin
            cyc(1);
            g++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        cyc(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/a_loaded"}, bus.a_loaded, m_a);
        chk({tag, "/b_loaded"}, bus.b_loaded, m_b);
        chk({tag, "/err"},      bus.err,      m_err);
        chk({tag, "/busy"},     bus.busy,     0);
        chk({tag, "/n_wr_a"},   n_wa,  e_wa);
        chk({tag, "/n_wr_b"},   n_wb,  e_wb);
        chk({tag, "/n_acc"},    n_acc, e_acc);
        chk({tag, "/n_clr"},    n_clr, e_clr);
    endtask

    task automatic load(input bit sel_b, input bit rnd, input bit per_pulse);
        logic [63:0] exp_v, got_v;
        logic [7:0]  d;
        exp_v = '0;
        got_v = '0;
        push(sel_b ? OP_LOAD_B : OP_LOAD_A);
        if (sel_b) m_b = 1'b0; else m_a = 1'b0;
        for (int i = 0; i < NB; i++) begin
            d = rnd ? 8'($urandom) : 8'(8'h10 + i);
            if (rnd) cyc($urandom_range(0, 2));
            push(d);
            if (per_pulse) begin
                chk("load/wr_a_en", bus.wr_a_en, !sel_b);
                chk("load/wr_b_en", bus.wr_b_en, sel_b);
                chk("load/wr_idx",  bus.wr_idx,  i);
                chk("load/wr_byte", bus.wr_byte, d);
            end
            exp_v[8*i +: 8] = d;
            if (sel_b) e_wb++; else e_wa++;
        end
        if (sel_b) m_b = 1'b1; else m_a = 1'b1;
        cyc(1);
        for (int i = 0; i < NB; i++) got_v[8*i +: 8] = sel_b ? mem_b[i] : mem_a[i];
        chk("load/operand", got_v, exp_v);
        check_state("load");
    endtask

    task automatic mac();
        push(OP_MAC);
        if (m_a && m_b) begin
            e_acc++;
            chk("mac/acc_en",   bus.acc_en,   1);
            chk("mac/busy",     bus.busy,     1);
            chk("mac/in_ready", bus.in_ready, 0);
        end else begin
            m_err = 1'b1;
        end
        cyc(1);
        check_state("mac");
    endtask

    task automatic clear();
        push(OP_CLEAR);
        e_clr++;
        chk("clear/acc_clr", bus.acc_clr, 1);
        cyc(1);
        check_state("clear");
    endtask

    task automatic junk(input logic [7:0] op);
        push(op);
        m_err = 1'b1;
        chk("junk/busy",     bus.busy,     0);
        chk("junk/in_ready", bus.in_ready, 1);
        cyc(1);
        check_state("junk");
    endtask

    task automatic rd(input bit alt);
        logic [63:0] exp_v, got_v;
        logic [7:0]  prev;
        bit          stall;
        int          k = 0;
        int          c = 0;
        res_base = alt ? 8'hA0 : 8'($urandom);
        exp_v = '0;
        got_v = '0;
        for (int i = 0; i < NB; i++) exp_v[8*i +: 8] = 8'(res_base + 8'(i));
        push(OP_READ);
        chk("read/out_valid", bus.out_valid, 1);
        chk("read/in_ready",  bus.in_ready,  0);
        while (k < NB && c < 200) begin
            bus.out_ready = alt ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            stall = !bus.out_ready;
            prev  = bus.out_byte;
            if (bus.out_ready) begin
                got_v[8*k +: 8] = bus.out_byte;
                k++;
            end
            cyc(1);
            c++;
            if (stall) begin
                chk("read/stall_valid", bus.out_valid, 1);
                chk("read/stall_byte",  bus.out_byte,  prev);
            end
        end
        bus.out_ready = 1'b0;
        chk("read/count", k, NB);
        chk("read/data",  got_v, exp_v);
        chk("read/out_valid_end", bus.out_valid, 0);
        check_state("read");
    endtask

    task automatic reset_mid_load();
        push(OP_LOAD_B);
        m_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(8'($urandom));
            e_wb++;
        end
        rst = 1'b0;
        cyc(1);
        chk("rst/in_ready_low", bus.in_ready, 0);
        cyc(1);
        m_a = 1'b0;
        m_b = 1'b0;
        m_err = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst/in_ready_release", bus.in_ready, 1);
        cyc(2);
        check_state("rst_mid_load");
    endtask

    initial begin
        logic [7:0] op;
        bus.in_byte   = 8'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        rst = 1'b0;
        cyc(3);
        chk("reset/in_ready",  bus.in_ready,  0);
        chk("reset/out_valid", bus.out_valid, 0);
        chk("reset/busy",      bus.busy,      0);
        chk("reset/pulses", {bus.wr_a_en, bus.wr_b_en, bus.acc_en, bus.acc_clr}, 0);
        chk("reset/flags",  {bus.a_loaded, bus.b_loaded, bus.err}, 0);
        rst = 1'b1;
        cyc(1);
        check_state("post_reset");

        load(1'b0, 1'b0, 1'b1);
        mac();
        load(1'b1, 1'b1, 1'b0);
        mac();
        rd(1'b1);
        clear();
        junk(8'hFF);
        load(1'b0, 1'b1, 1'b1);
        reset_mid_load();

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: load(1'b0, 1'b1, 1'b0);
                1: load(1'b1, 1'b1, 1'b0);
                2: mac();
                3: clear();
                4: rd(1'b0);
                default: begin
                    do op = 8'($urandom); while (op >= 8'h01 && op <= 8'h05);
                    junk(op);
                end
            endcase
        end

        chk("exclusive_pulses", n_excl, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
